// File: rtl/fifo_rd_checker.sv
// rtl/fifo_rd_checker.sv - read-side pattern checker that drains a FIFO and verifies a decrementing sequence
// Optional watchdog abort is compiled in with CHK_TIMEOUT_EN.

module fifo_rd_checker #(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    LEVEL_WIDTH    = 9,
    parameter int                    BURST_LEN      = 256,
    parameter logic [DATA_WIDTH-1:0] SEED           = DATA_WIDTH'(8'hFF),
    parameter int                    RD_LATENCY     = 2,
    parameter int                    START_LEVEL    = 4,
    parameter int                    TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   rd_en,
    input  logic                   rd_empty,
    input  logic [DATA_WIDTH-1:0]  rd_data,
    input  logic [LEVEL_WIDTH-1:0] rd_water_level,
    output logic                   busy,
    output logic                   done,
    output logic                   err_flag,
    output logic [7:0]             err_cnt,
    output logic [16:0]            words_checked,
    output logic [DATA_WIDTH-1:0]  first_err_exp,
    output logic [DATA_WIDTH-1:0]  first_err_got,
    output logic                   timeout
);

    localparam int CW = 17;

    if (BURST_LEN < 1 || BURST_LEN > 65536) begin : g_bad_burst_len
        $error("fifo_rd_checker: BURST_LEN must be 1..65536");
    end
    if (RD_LATENCY < 1) begin : g_bad_rd_latency
        $error("fifo_rd_checker: RD_LATENCY must be at least 1");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
        $error("fifo_rd_checker: TIMEOUT_CYCLES must be 1..65536");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CW-1:0]           issue_cnt;
    logic [RD_LATENCY-1:0]   vpipe;
    logic [DATA_WIDTH-1:0]   expected;
    logic [CW-1:0]           level;
    logic                    start_ok;
    logic                    last_issue;
    logic                    level_ok;
    logic                    tail;
    logic                    mismatch;
    logic                    timeout_hit;

    assign start_ok   = (state == S_IDLE) && start;
    assign last_issue = rd_en && (issue_cnt == CW'(1));
    assign level      = CW'(rd_water_level);
    // A short final burst may never reach START_LEVEL, so also go once the remainder is buffered.
    assign level_ok   = (level >= CW'(START_LEVEL)) || (level >= issue_cnt);
    assign tail       = vpipe[RD_LATENCY-1];
    assign mismatch   = tail && (rd_data != expected);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (timeout_hit) begin
                    state_next = S_DRAIN;
                end else if (level_ok) begin
                    state_next = S_READ;
                end
            end
            S_READ: begin
                if (last_issue || timeout_hit) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (vpipe == '0) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        rd_en = 1'b0;
        busy  = 1'b1;
        done  = 1'b0;
        case (state)
            S_IDLE:  busy  = 1'b0;
            S_READ:  rd_en = !rd_empty && (issue_cnt != '0);
            S_DONE:  done  = 1'b1;
            default: ;
        endcase
    end

    // Issue side: remaining reads, latency-matching valid pipe, and the expected pattern.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt <= '0;
            vpipe     <= '0;
            expected  <= SEED;
        end else begin
            vpipe <= (vpipe << 1) | RD_LATENCY'(rd_en);
            if (start_ok) begin
                issue_cnt <= CW'(BURST_LEN);
                expected  <= SEED;
            end else begin
                if (rd_en) begin
                    issue_cnt <= issue_cnt - CW'(1);
                end
                if (tail) begin
                    expected <= expected - DATA_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flag      <= 1'b0;
            err_cnt       <= 8'h00;
            words_checked <= '0;
            first_err_exp <= '0;
            first_err_got <= '0;
        end else if (start_ok) begin
            err_flag      <= 1'b0;
            err_cnt       <= 8'h00;
            words_checked <= '0;
            first_err_exp <= '0;
            first_err_got <= '0;
        end else if (tail) begin
            words_checked <= words_checked + CW'(1);
            if (mismatch) begin
                err_flag <= 1'b1;
                if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
                if (err_cnt == 8'h00) begin
                    first_err_exp <= expected;
                    first_err_got <= rd_data;
                end
            end
        end
    end

`ifdef CHK_TIMEOUT_EN
    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wd_cnt;
    logic        timeout_q;
    logic        wd_active;

    assign wd_active   = (state == S_WAIT) || (state == S_READ);
    // wd_cnt holds the number of idle cycles before this one, so the limit cycle is the last idle one allowed.
    assign timeout_hit = wd_active && !rd_en && (wd_cnt == WD_LIMIT);
    assign timeout     = timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt    <= 16'd0;
            timeout_q <= 1'b0;
        end else if (start_ok) begin
            wd_cnt    <= 16'd0;
            timeout_q <= 1'b0;
        end else if (wd_active) begin
            if (rd_en || timeout_hit) begin
                wd_cnt <= 16'd0;
            end else begin
                wd_cnt <= wd_cnt + 16'd1;
            end
            if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
        end else begin
            wd_cnt <= 16'd0;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_checker.sv
// tb/tb_fifo_rd_checker.sv - directed bench: FIFO model with output register feeding two checkers (latency 2 and 1)

module tb_fifo_rd_checker;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic start1 = 1'b0;

    logic        rd_en0, rd_en1, busy0, busy1, done0, done1;
    logic        err_flag0, err_flag1, timeout0, timeout1;
    logic [7:0]  err_cnt0, err_cnt1, fexp0, fexp1, fgot0, fgot1;
    logic [16:0] wc0, wc1;
    logic        empty0, empty1;
    logic [8:0]  lvl0, lvl1;

    logic [7:0]  mem [2][512];
    int unsigned wp  [2] = '{0, 0};
    int unsigned rp  [2] = '{0, 0};
    logic [7:0]  raw [2] = '{8'h00, 8'h00};
    logic [7:0]  rdq [2] = '{8'h00, 8'h00};
    logic        rdv [2];
    int          viol = 0;

    int checks = 0;
    int errors = 0;
    bit d1_seen;

    always #5 clk = ~clk;

    assign empty0 = (wp[0] == rp[0]);
    assign empty1 = (wp[1] == rp[1]);
    assign lvl0   = 9'(wp[0] - rp[0]);
    assign lvl1   = 9'(wp[1] - rp[1]);
    assign rdv[0] = rd_en0;
    assign rdv[1] = rd_en1;

    // FIFO with output register: data popped at edge n appears on rdq after edge n+1.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                rp[i]  <= wp[i];
                raw[i] <= 8'h00;
                rdq[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                rdq[i] <= raw[i];
                if (rdv[i]) begin
                    if (rp[i] == wp[i]) begin
                        viol <= viol + 1;
                    end else begin
                        raw[i] <= mem[i][rp[i] % 512];
                        rp[i]  <= rp[i] + 1;
                    end
                end
            end
        end
    end

    fifo_rd_checker #(.RD_LATENCY(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rd_en(rd_en0), .rd_empty(empty0),
        .rd_data(rdq[0]), .rd_water_level(lvl0), .busy(busy0), .done(done0),
        .err_flag(err_flag0), .err_cnt(err_cnt0), .words_checked(wc0),
        .first_err_exp(fexp0), .first_err_got(fgot0), .timeout(timeout0)
    );

    fifo_rd_checker #(.RD_LATENCY(1)) dut_lat1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .rd_en(rd_en1), .rd_empty(empty1),
        .rd_data(rdq[1]), .rd_water_level(lvl1), .busy(busy1), .done(done1),
        .err_flag(err_flag1), .err_cnt(err_cnt1), .words_checked(wc1),
        .first_err_exp(fexp1), .first_err_got(fgot1), .timeout(timeout1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int i, input logic [7:0] d);
        mem[i][wp[i] % 512] = d;
        wp[i] = wp[i] + 1;
    endtask

    task automatic preload(input int i, input int n, input int bad);
        for (int k = 0; k < n; k++) begin
            push(i, (k == bad) ? 8'h00 : 8'(255 - k));
        end
    endtask

    task automatic pulse_start(input bit both);
        @(negedge clk);
        start  = 1'b1;
        start1 = both;
        @(negedge clk);
        start  = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done(input int max, output bit ok, output int nrd,
                             output int last_c, output int done_c);
        ok = 1'b0; nrd = 0; last_c = 0; done_c = 0;
        for (int c = 0; c < max; c++) begin
            @(negedge clk);
            if (rd_en0) begin
                nrd++;
                last_c = c;
            end
            if (done1) d1_seen = 1'b1;
            if (done0) begin
                ok = 1'b1;
                done_c = c;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        int nrd, last_c, done_c, written;
        bit dseen;

        repeat (3) @(negedge clk);
        chk("rst_rd_en", rd_en0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_err_flag", err_flag0, 0);
        chk("rst_err_cnt", err_cnt0, 0);
        chk("rst_words", wc0, 0);
        chk("rst_first_exp", fexp0, 0);
        chk("rst_timeout", timeout0, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Clean burst, with the latency-1 checker draining an identical FIFO alongside.
        preload(0, 256, -1);
        preload(1, 256, -1);
        d1_seen = 1'b0;
        pulse_start(1'b1);
        chk("clean_busy", busy0, 1);
        wait_done(2000, ok, nrd, last_c, done_c);
        chk("clean_done", ok, 1);
        chk("clean_rd_cnt", nrd, 256);
        chk("clean_err_cnt", err_cnt0, 0);
        chk("clean_err_flag", err_flag0, 0);
        chk("clean_words", wc0, 256);
        @(negedge clk);
        chk("clean_done_1cyc", done0, 0);
        chk("clean_idle", busy0, 0);
        chk("lat1_done", d1_seen, 1);
        chk("lat1_err_flag", err_flag1, 1);
        chk("lat1_err_cnt_sat", err_cnt1, 8'hFF);
        chk("lat1_words", wc1, 256);
        chk("lat1_first_exp", fexp1, 8'hFF);
        chk("lat1_first_got", fgot1, 8'h00);

        // Word 10 (expected F5) corrupted to 00.
        preload(0, 256, 10);
        pulse_start(1'b0);
        wait_done(2000, ok, nrd, last_c, done_c);
        chk("corr_done", ok, 1);
        chk("corr_err_cnt", err_cnt0, 1);
        chk("corr_err_flag", err_flag0, 1);
        chk("corr_first_exp", fexp0, 8'hF5);
        chk("corr_first_got", fgot0, 8'h00);
        chk("corr_words", wc0, 256);

        // Throttled writer: one word every third cycle into an empty FIFO.
        pulse_start(1'b0);
        chk("start_clr_err_cnt", err_cnt0, 0);
        chk("start_clr_err_flag", err_flag0, 0);
        chk("start_clr_first_exp", fexp0, 0);
        chk("start_clr_words", wc0, 0);
        written = 0; nrd = 0; ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ((c % 3) == 0 && written < 256) begin
                push(0, 8'(255 - written));
                written++;
            end
            #1;
            if (rd_en0) nrd++;
            if (done0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("thr_done", ok, 1);
        chk("thr_rd_cnt", nrd, 256);
        chk("thr_err_cnt", err_cnt0, 0);
        chk("thr_words", wc0, 256);
        chk("thr_no_empty_read", viol, 0);

        // Reset after 100 reads, then a fresh clean burst.
        preload(0, 256, -1);
        pulse_start(1'b0);
        nrd = 0;
        for (int c = 0; c < 1000 && nrd < 100; c++) begin
            @(negedge clk);
            if (rd_en0) nrd++;
        end
        chk("mid_reads", nrd, 100);
        @(negedge clk);
        chk("mid_words", wc0, 98);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy0, 0);
        chk("mid_rst_rd_en", rd_en0, 0);
        chk("mid_rst_words", wc0, 0);
        chk("mid_rst_err_cnt", err_cnt0, 0);
        chk("mid_rst_done", done0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        preload(0, 256, -1);
        pulse_start(1'b0);
        wait_done(2000, ok, nrd, last_c, done_c);
        chk("rerun_done", ok, 1);
        chk("rerun_rd_cnt", nrd, 256);
        chk("rerun_err_cnt", err_cnt0, 0);
        chk("rerun_err_flag", err_flag0, 0);
        chk("rerun_words", wc0, 256);

        // Short supply: only 100 of 256 words ever arrive.
        preload(0, 100, -1);
        pulse_start(1'b0);
`ifdef CHK_TIMEOUT_EN
        wait_done(3000, ok, nrd, last_c, done_c);
        chk("to_done", ok, 1);
        chk("to_flag", timeout0, 1);
        chk("to_words", wc0, 100);
        chk("to_rd_cnt", nrd, 100);
        chk("to_done_gap", done_c - last_c, 1026);
        pulse_start(1'b0);
        chk("to_clr_on_start", timeout0, 0);
`else
        nrd = 0; dseen = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (rd_en0) nrd++;
            if (done0) dseen = 1'b1;
        end
        chk("short_rd_cnt", nrd, 100);
        chk("short_words", wc0, 100);
        chk("short_still_busy", busy0, 1);
        chk("short_no_done", dseen, 0);
        chk("short_no_timeout", timeout0, 0);
`endif
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("final_no_empty_read", viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
